// File: rtl/param_sync_fifo.sv
// Single-clock FIFO with pointer-derived full/empty, registered occupancy count,
// threshold flags, sticky overflow/underflow and selectable registered or FWFT read.
module param_sync_fifo #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 8,
    parameter int FWFT     = 0,
    parameter int AF_LEVEL = DEPTH - 1,
    parameter int AE_LEVEL = 1,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic             wclk,
    input  logic             rst,
    input  logic             winc,
    input  logic [WIDTH-1:0] wdata,
    input  logic             rinc,
    input  logic             clr_err,
    output logic [WIDTH-1:0] rdata,
    output logic             rvalid,
    output logic             wfull,
    output logic             rempty,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [AW:0]      count,
    output logic             overflow,
    output logic             underflow
);

    localparam logic [AW:0] ONE  = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0] AF_L = AF_LEVEL[AW:0];
    localparam logic [AW:0] AE_L = AE_LEVEL[AW:0];

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic             rvalid_q, rvalid_d;
    logic             wfull_s, rempty_s, wr_en_s, rd_en_s;
    logic [AW-1:0]    rd_addr_s;

    assign wfull_s   = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign rempty_s  = (wr_ptr_q == rd_ptr_q);
    // Full/empty gating alone resolves the simultaneous-request corner cases
    assign wr_en_s   = winc && !wfull_s;
    assign rd_en_s   = rinc && !rempty_s;
    assign rd_addr_s = rd_ptr_q[AW-1:0];

    // Next-state for pointers, occupancy, sticky errors and registered read port
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        rdata_d     = rdata_q;
        rvalid_d    = 1'b0;
        if (wr_en_s) begin
            wr_ptr_d = wr_ptr_q + ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (rd_en_s) begin
            rd_ptr_d = rd_ptr_q + ONE;
            rdata_d  = mem_q[rd_addr_s];
            rvalid_d = 1'b1;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({wr_en_s, rd_en_s})
            2'b10:   count_d = count_q + ONE;
            2'b01:   count_d = count_q - ONE;
            default: count_d = count_q;
        endcase
        // A new error event outranks a clear in the same cycle
        if (winc && wfull_s) begin
            overflow_d = 1'b1;
        end else if (clr_err) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end
        if (rinc && rempty_s) begin
            underflow_d = 1'b1;
        end else if (clr_err) begin
            underflow_d = 1'b0;
        end else begin
            underflow_d = underflow_q;
        end
    end

    // Control state registers with synchronous reset
    always_ff @(posedge wclk) begin
        if (rst) begin
            wr_ptr_q    <= {(AW+1){1'b0}};
            rd_ptr_q    <= {(AW+1){1'b0}};
            count_q     <= {(AW+1){1'b0}};
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            rdata_q     <= {WIDTH{1'b0}};
            rvalid_q    <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            rdata_q     <= rdata_d;
            rvalid_q    <= rvalid_d;
        end
    end

    // Storage array; intentionally not reset, stale words are unreachable after rst
    always_ff @(posedge wclk) begin
        if (wr_en_s && !rst) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign rdata  = mem_q[rd_addr_s];
            assign rvalid = !rempty_s;
        end else begin : g_reg
            assign rdata  = rdata_q;
            assign rvalid = rvalid_q;
        end
    endgenerate

    assign wfull        = wfull_s;
    assign rempty       = rempty_s;
    assign count        = count_q;
    assign almost_full  = (count_q >= AF_L);
    assign almost_empty = (count_q <= AE_L);
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

endmodule

// File: doc/param_sync_fifo.md
PARAM_SYNC_FIFO -- requirements
Module: param_sync_fifo

Interface
REQ-001 SHALL have parameter WIDTH, default 32: data word width in bits (>=1).
REQ-002 SHALL have parameter DEPTH, default 8: entries; power of two, >=2; AW=$clog2(DEPTH).
REQ-003 SHALL have parameter FWFT, default 0: 0 = registered-read mode, 1 = first-word-fall-through mode.
REQ-004 SHALL have parameter AF_LEVEL, default DEPTH-1: almost_full asserts when count>=AF_LEVEL.
REQ-005 SHALL have parameter AE_LEVEL, default 1: almost_empty asserts when count<=AE_LEVEL.
REQ-006 SHALL have port wclk  input  1  clock; all state updates on its rising edge.
REQ-007 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-008 SHALL have port winc  input  1  write request.
REQ-009 SHALL have port wdata  input  WIDTH  write data.
REQ-010 SHALL have port rinc  input  1  read/pop request.
REQ-011 SHALL have port clr_err  input  1  clears sticky error flags.
REQ-012 SHALL have port rdata  output  WIDTH  read data.
REQ-013 SHALL have port rvalid  output  1  rdata qualifier.
REQ-014 SHALL have port wfull  output  1  count==DEPTH.
REQ-015 SHALL have port rempty  output  1  count==0.
REQ-016 SHALL have port almost_full / almost_empty  output  1 each  threshold flags.
REQ-017 SHALL have port count  output  AW+1  current occupancy, 0..DEPTH.
REQ-018 SHALL have port overflow / underflow  output  1 each  sticky error flags.

Function
REQ-019 SHALL keep wr_ptr, rd_ptr of AW+1 bits; address = low AW bits; wrap from DEPTH-1 to 0 by natural overflow.
REQ-020 SHALL derive wfull as MSBs differ and low AW bits equal; rempty as pointers equal; both combinational from registers.
REQ-021 SHALL accept a write (store wdata at wr_ptr, wr_ptr+1) iff winc && !wfull.
REQ-022 SHALL accept a pop (rd_ptr+1) iff rinc && !rempty.
REQ-023 SHALL, when full and winc&&rinc, accept only the pop; write is dropped, count becomes DEPTH-1.
REQ-024 SHALL, when empty and winc&&rinc, accept only the write; count becomes 1.
REQ-025 SHALL, otherwise on simultaneous accepted write and pop, leave count unchanged.
REQ-026 SHALL register count: +1 on write-only, -1 on pop-only, else hold; count SHALL always equal wr_ptr-rd_ptr (AW+1-bit modulo).
REQ-027 FWFT=0: on accepted pop, rdata SHALL be loaded with mem[rd_ptr] at that edge (1-cycle latency) and rvalid SHALL be 1 for exactly the following cycle; otherwise rvalid=0 and rdata holds its last value.
REQ-028 FWFT=1: rdata SHALL equal mem[rd_ptr] combinationally and rvalid SHALL equal !rempty; a word written into an empty FIFO SHALL appear with rvalid=1 the cycle after the write edge.
REQ-029 SHALL set overflow on any cycle with winc && wfull, and underflow on any cycle with rinc && rempty; flags hold until cleared.
REQ-030 SHALL clear both flags on clr_err; if clr_err coincides with a new error event, the flag SHALL be set (set wins).
REQ-031 almost_full/almost_empty SHALL be combinational compares of registered count.
REQ-032 Memory contents SHALL NOT be reset; only pointers, count, flags, rdata, rvalid.

Reset
REQ-033 SHALL, on rst at a rising edge, set wr_ptr=rd_ptr=0, count=0, rdata=0, FWFT=0 rvalid=0, overflow=underflow=0; rst overrides winc/rinc/clr_err that cycle.
REQ-034 SHALL, after rst mid-operation, present rempty=1, wfull=0, almost_empty=1, almost_full=0 (AF_LEVEL>0), discarding all stored words.

Verification
REQ-035 Fill/drain (DEPTH=8, FWFT=0): write 0x11..0x88 -> wfull=1, count=8; 8 pops -> rdata 0x11..0x88 each one cycle after rinc with rvalid pulse, then rempty=1.
REQ-036 Overflow/underflow: 9th write 0x99 when full -> dropped, overflow=1 held; pop on empty -> underflow=1, count stays 0; clr_err -> both 0.
REQ-037 Full simultaneous: full FIFO, winc=rinc=1 with 0xAA -> pop of oldest word, 0xAA dropped, count=7, overflow=1.
REQ-038 FWFT=1: write 0x5A to empty -> next cycle rdata=0x5A, rvalid=1 without rinc; rinc -> rvalid=0, rempty=1.
REQ-039 Wrap-around: 3 cycles write+pop steady state over 20 words -> in-order data, count constant, pointers wrap cleanly past 8.
REQ-040 Reset mid-operation: count=5, assert rst with winc=1 -> count=0, rempty=1, no write stored, flags 0.
